// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// State encodings: IDLE=0, LOAD=1, FLUSH=2, RUN=3, ERROR=4.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StFlush = 3'd2,
    StRun   = 3'd3,
    StError = 3'd4
  } state_e;

  localparam int unsigned DefAddrW       = 12;
  localparam int unsigned DefFlushCycles = 4;

  // Counter must hold FLUSH_CYCLES+1: the load happens one cycle before the final write shows.
  function automatic int unsigned flush_cnt_width(input int unsigned flush_cycles);
    return $clog2(flush_cycles + 2);
  endfunction

endpackage

// File: rtl/imem_loader_flush.sv
// Loadable down-counter for the flush phase; tc_o pulses for the single cycle the count is 1.
module loader_flush_timer #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(1)) && !load_i;

endmodule

// File: rtl/imem_loader.sv
// Streams a program into imem while holding the processor in reset, then releases it.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to treat the last word as a checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned FLUSH_CYCLES = DefFlushCycles
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [31:0]       in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic [ADDR_W-1:0] imem_address_o,
  output logic [31:0]       imem_data_o,
  output logic              imem_wren_o,
  output logic              proc_reset_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int unsigned CntW = flush_cnt_width(FLUSH_CYCLES);
  localparam logic [ADDR_W-1:0] PtrMax = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   WcMax  = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   wc_q;
  logic              in_ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              wren_q;
  logic              proc_reset_q;
  logic              done_q;
  logic              error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q;
`endif

  logic accept;
  logic do_write;
  logic go_flush;
  logic go_error;
  logic flush_tc;

  assign accept = in_valid_i && in_ready_q;

  always_comb begin
    do_write = accept;
    go_flush = accept && in_last_i;
    go_error = accept && !in_last_i && (ptr_q == PtrMax);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (accept && in_last_i) begin
      do_write = 1'b0;
      go_flush = (sum_q == in_data_i);
      go_error = (sum_q != in_data_i);
    end
`endif
  end

  loader_flush_timer #(
    .CntW (CntW)
  ) u_flush_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     ((state_q == StLoad) && go_flush),
    .load_val_i (CntW'(FLUSH_CYCLES + 1)),
    .tc_o       (flush_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      wc_q         <= '0;
      in_ready_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wren_q       <= 1'b0;
      proc_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      wren_q <= 1'b0;
      unique case (state_q)
        StIdle, StRun, StError: begin
          if (start_i) begin
            state_q      <= StLoad;
            ptr_q        <= '0;
            wc_q         <= '0;
            in_ready_q   <= 1'b1;
            proc_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
          end
        end
        StLoad: begin
          if (do_write) begin
            wren_q <= 1'b1;
            addr_q <= ptr_q;
            data_q <= in_data_i;
            ptr_q  <= ptr_q + 1'b1;
            wc_q   <= (wc_q == WcMax) ? wc_q : wc_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q  <= sum_q + in_data_i;
`endif
          end
          if (go_flush) begin
            state_q    <= StFlush;
            in_ready_q <= 1'b0;
          end else if (go_error) begin
            state_q    <= StError;
            in_ready_q <= 1'b0;
            error_q    <= 1'b1;
          end
        end
        StFlush: begin
          if (flush_tc) begin
            state_q      <= StRun;
            proc_reset_q <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        default: begin
          state_q      <= StIdle;
          in_ready_q   <= 1'b0;
          proc_reset_q <= 1'b1;
          done_q       <= 1'b0;
          error_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign imem_address_o = addr_q;
  assign imem_data_o    = data_q;
  assign imem_wren_o    = wren_q;
  assign proc_reset_o   = proc_reset_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign word_count_o   = wc_q;

endmodule
